pll_lock_sequencer: RTL and testbench

//  Sequences the board rPLL: pulses its RESET, waits for LOCK, and qualifies lock stability.

---
 rtl/pll_lock_sequencer.sv | 157 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: pulses the rPLL RESET, waits for and qualifies LOCK, then releases sys_rst.
// Define PLL_SEQ_LOSS_CNT_EN to add the saturating lock_loss_cnt output.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 270000,
    parameter int STABLE_CYC       = 2700,
    parameter int MAX_RETRY        = 4
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       restart,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic [2:0] state_o
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYC) ? MAX_AB : STABLE_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_PULSE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYC - 1);
    localparam logic [2:0]    RETRY_LIMIT = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_WAIT = 3'd1,
        S_STAB = 3'd2,
        S_RUN  = 3'd3,
        S_FAIL = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    retry_q, retry_d;
    logic          pll_reset_q, pll_reset_d;
    logic          sys_rst_q, sys_rst_d;
    logic          ready_q, ready_d;
    logic          fail_q, fail_d;
    logic          lock_meta_q, lock_s_q;

    // LOCK is asynchronous to clkin, so it is only ever used after two flops.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (restart) begin
            state_d = S_RST;
            retry_d = 3'd0;
        end else begin
            case (state_q)
                S_RST:  if (timer_q == RST_LAST) state_d = S_WAIT;
                S_WAIT: begin
                    if (lock_s_q) begin
                        state_d = S_STAB;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        retry_d = retry_q + 3'd1;
                        state_d = (retry_d == RETRY_LIMIT) ? S_FAIL : S_RST;
                    end
                end
                S_STAB: begin
                    if (!lock_s_q) begin
                        state_d = S_WAIT;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        retry_d = 3'd0;
                    end
                end
                S_RUN:   if (!lock_s_q) state_d = S_RST;
                S_FAIL:  state_d = S_FAIL;
                default: state_d = S_RST;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        timer_d = timer_q;
        if (restart || (state_d != state_q)) begin
            timer_d = '0;
        end else if (state_q inside {S_RST, S_WAIT, S_STAB}) begin
            timer_d = timer_q + 1'b1;
        end
        pll_reset_d = (state_d == S_RST) || (state_d == S_FAIL);
        sys_rst_d   = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
        fail_d      = (state_d == S_FAIL);
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= S_RST;
            timer_q     <= '0;
            retry_q     <= 3'd0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign state_o   = state_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    // Survives restart on purpose: it records in-service lock drops since power-up.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (!restart && (state_q == S_RUN) && !lock_s_q && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            loss_cnt_q <= 8'd0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: table vectors, hand-built corner sequences and random lock/restart
// traffic for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;

    localparam int RST_CYC   = 4;
    localparam int TO_CYC    = 50;
    localparam int ST_CYC    = 10;
    localparam int MAX_RETRY = 2;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset, sys_rst, ready, fail;
    logic [2:0] retry_cnt, state_o;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clkin = ~clkin;

    pll_lock_sequencer #(
        .RST_PULSE_CYC(RST_CYC),
        .LOCK_TIMEOUT_CYC(TO_CYC),
        .STABLE_CYC(ST_CYC),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clkin(clkin),
        .reset(reset),
        .restart(restart),
        .pll_lock(pll_lock),
        .pll_reset(pll_reset),
        .sys_rst(sys_rst),
        .ready(ready),
        .fail(fail),
        .retry_cnt(retry_cnt),
        .state_o(state_o)
`ifdef PLL_SEQ_LOSS_CNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    typedef struct {
        logic       rs;
        logic       lk;
        int         cycles;
        int         st;
        logic       prst;
        logic       srst;
        logic       rdy;
        logic       fl;
        int         rc;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic rs, input logic lk, input int n, input int st,
                          input logic pr, input logic sr, input logic rd, input logic fl,
                          input int rc);
        vec_t v;
        v.rs = rs; v.lk = lk; v.cycles = n; v.st = st;
        v.prst = pr; v.srst = sr; v.rdy = rd; v.fl = fl; v.rc = rc;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input int st, input logic pr, input logic sr,
                               input logic rd, input logic fl, input int rc);
        logic [9:0] exp_v;
        logic [9:0] act_v;
        exp_v = {3'(st), pr, sr, rd, fl, 3'(rc)};
        act_v = {state_o, pll_reset, sys_rst, ready, fail, retry_cnt};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s @%0t: got state=%0d pll_reset=%b sys_rst=%b ready=%b fail=%b retry=%0d, expected state=%0d pll_reset=%b sys_rst=%b ready=%b fail=%b retry=%0d",
                     name, $time, state_o, pll_reset, sys_rst, ready, fail, retry_cnt,
                     st, pr, sr, rd, fl, rc);
        end
    endtask

`ifdef PLL_SEQ_LOSS_CNT_EN
    task automatic checkLoss(input string name, input int expv);
        checks++;
        if (lock_loss_cnt !== 8'(expv)) begin
            failures++;
            $display("[TB] FAIL %s: got lock_loss_cnt=%0d, expected %0d", name, lock_loss_cnt, expv);
        end
    endtask
`endif

    // Inputs change 1 time unit after a rising edge, then n rising edges elapse.
    task automatic applyStimulus(input logic rs, input logic lk, input int n);
        restart  = rs;
        pll_lock = lk;
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic doReset(input logic lk);
        reset    = 1'b1;
        restart  = 1'b0;
        pll_lock = lk;
        repeat (2) @(posedge clkin);
        #1;
        reset = 1'b0;
    endtask

    // Behavioural model: phase codes 0..4 = reset pulse, wait lock, stabilise, run, failed.
    int   m_phase, m_elapsed, m_retry, m_loss;
    logic m_hist[2];
    logic m_seen;
    bit   model_chk = 1'b0;

    task automatic enterPhase(input int p);
        m_phase   = p;
        m_elapsed = 0;
    endtask

    always @(posedge clkin or posedge reset) begin
        if (reset) begin
            enterPhase(0);
            m_retry   = 0;
            m_loss    = 0;
            m_hist[0] = 1'b0;
            m_hist[1] = 1'b0;
        end else begin
            m_seen    = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = pll_lock;
            m_elapsed = m_elapsed + 1;
            if (restart) begin
                enterPhase(0);
                m_retry = 0;
            end else begin
                case (m_phase)
                    0: if (m_elapsed == RST_CYC) enterPhase(1);
                    1: begin
                        if (m_seen) enterPhase(2);
                        else if (m_elapsed == TO_CYC) begin
                            m_retry = m_retry + 1;
                            enterPhase((m_retry == MAX_RETRY) ? 4 : 0);
                        end
                    end
                    2: begin
                        if (!m_seen) enterPhase(1);
                        else if (m_elapsed == ST_CYC) begin
                            enterPhase(3);
                            m_retry = 0;
                        end
                    end
                    3: begin
                        if (!m_seen) begin
                            enterPhase(0);
                            if (m_loss < 255) m_loss = m_loss + 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clkin) begin
        if (model_chk && !reset) begin
            checkOutput("random_vs_model", m_phase, (m_phase == 0) || (m_phase == 4),
                        m_phase != 3, m_phase == 3, m_phase == 4, m_retry);
`ifdef PLL_SEQ_LOSS_CNT_EN
            checkLoss("random_loss_cnt", m_loss);
`endif
        end
    end

    int   run_left;
    logic rnd_lk, rnd_rs;

    initial begin
        // Edge numbers below count rising edges after reset release.
        addVec(0, 0,  0, 0, 1, 1, 0, 0, 0);
        addVec(0, 0,  3, 0, 1, 1, 0, 0, 0);
        addVec(0, 0,  1, 1, 0, 1, 0, 0, 0);
        addVec(0, 0, 49, 1, 0, 1, 0, 0, 0);
        addVec(0, 0,  1, 0, 1, 1, 0, 0, 1);
        addVec(0, 0,  3, 0, 1, 1, 0, 0, 1);
        addVec(0, 0,  1, 1, 0, 1, 0, 0, 1);
        addVec(0, 0, 49, 1, 0, 1, 0, 0, 1);
        addVec(0, 0,  1, 4, 1, 1, 0, 1, 2);
        addVec(0, 0, 12, 4, 1, 1, 0, 1, 2);
        addVec(1, 0,  1, 0, 1, 1, 0, 0, 0);
        addVec(0, 0,  3, 0, 1, 1, 0, 0, 0);
        addVec(0, 0,  1, 1, 0, 1, 0, 0, 0);
        addVec(0, 1, 12, 2, 0, 1, 0, 0, 0);
        addVec(0, 1,  1, 3, 0, 0, 1, 0, 0);
        addVec(0, 0,  2, 3, 0, 0, 1, 0, 0);
        addVec(0, 0,  1, 0, 1, 1, 0, 0, 0);
        addVec(0, 1,  4, 1, 0, 1, 0, 0, 0);
        addVec(0, 1,  1, 2, 0, 1, 0, 0, 0);
        addVec(0, 1,  9, 2, 0, 1, 0, 0, 0);
        addVec(0, 1,  1, 3, 0, 0, 1, 0, 0);

        repeat (3) @(posedge clkin);
        #1;
        checkOutput("reset_values", 0, 1, 1, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rs, vecs[i].lk, vecs[i].cycles);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].prst, vecs[i].srst,
                        vecs[i].rdy, vecs[i].fl, vecs[i].rc);
        end
`ifdef PLL_SEQ_LOSS_CNT_EN
        checkLoss("loss_after_relock", 1);
`endif

        // Lock drops for three cycles while stabilising at timer 5.
        doReset(1'b1);
        applyStimulus(0, 1, 10);
        checkOutput("glitch_in_stab", 2, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 3);
        checkOutput("glitch_back_to_wait", 1, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 3);
        checkOutput("glitch_restab", 2, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 9);
        checkOutput("glitch_not_yet_ready", 2, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1);
        checkOutput("glitch_ready", 3, 0, 0, 1, 0, 0);

        // Lock seen on the timeout cycle, then lost on the stable-done cycle.
        doReset(1'b0);
        applyStimulus(0, 0, 51);
        checkOutput("pre_timeout", 1, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 3);
        checkOutput("lock_wins_timeout", 2, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 7);
        checkOutput("stab_before_done", 2, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 3);
        checkOutput("loss_on_stable_done", 1, 0, 1, 0, 0, 0);

        // One timeout, then a good lock clears the retry count on entering run.
        doReset(1'b0);
        applyStimulus(0, 0, 54);
        checkOutput("first_timeout", 0, 1, 1, 0, 0, 1);
        applyStimulus(0, 1, 14);
        checkOutput("stab_keeps_retry", 2, 0, 1, 0, 0, 1);
        applyStimulus(0, 1, 1);
        checkOutput("run_clears_retry", 3, 0, 0, 1, 0, 0);

        // Reset asserted between edges while stabilising.
        doReset(1'b1);
        applyStimulus(0, 1, 8);
        checkOutput("pre_async_stab", 2, 0, 1, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 0, 1, 1, 0, 0, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
        checkLoss("async_reset_loss", 0);
`endif

        doReset(1'b0);
        model_chk = 1'b1;
        run_left  = 0;
        rnd_lk    = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                rnd_lk   = 1'($urandom_range(0, 1));
                run_left = rnd_lk ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 70));
            end
            run_left = run_left - 1;
            rnd_rs   = ($urandom_range(0, 299) == 0);
            applyStimulus(rnd_rs, rnd_lk, 1);
        end
        @(negedge clkin);
        model_chk = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
